ks_final_sum: RTL



---
 rtl/ks_pkg.sv | 16 +
 rtl/lzc_count.sv | 25 ++
 rtl/ks_final_sum.sv | 100 ++++++++++
 3 files changed

// File: rtl/ks_pkg.sv
// Shared types and constants for the Kogge-Stone adder tail and the normalizer.
package ks_pkg;

    localparam int KS_WIDTH = 25;
    localparam int KS_LZW   = 5;

    // Result word handed to the normalizer.
    typedef struct packed {
        logic [KS_WIDTH-1:0] sum;
        logic                cout;
        logic [KS_LZW-1:0]   lzc;
        logic                zero;
        logic                sign;
    } ks_result_t;

endpackage

// File: rtl/lzc_count.sv
// Combinational leading-zero counter: count of zeros above the highest set bit.
// An all-zero input reports W and raises zero.
module lzc_count #(
    parameter int W  = 26,
    parameter int CW = 5
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] count,
    output logic          zero
);

    // Scan upward so the highest set bit is the last one to set the count.
    always_comb begin
        count = CW'(W);
        zero  = (din == {W{1'b0}});
        for (int i = 0; i < W; i++) begin
            if (din[i]) begin
                count = CW'(W - 1 - i);
            end else begin
                count = count;
            end
        end
    end

endmodule

// File: rtl/ks_final_sum.sv
// Final sum stage of the Kogge-Stone adder: sum/carry register (S1) followed by
// a leading-zero/zero-flag register (S2), both under valid/ready flow control.
module ks_final_sum
    import ks_pkg::*;
#(
    parameter int WIDTH = KS_WIDTH,
    parameter int LZW   = KS_LZW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_P0,
    input  logic [WIDTH-1:0] in_GG,
    input  logic             in_sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic [LZW-1:0]   out_lzc,
    output logic             out_zero,
    output logic             out_sign
);

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_sum_r;
    logic             s1_cout_r;
    logic             s1_sign_r;
    logic             s2_valid_r;
    ks_result_t       s2_r;

    logic [WIDTH-1:0] sum_s;
    logic [LZW-1:0]   lzc_s;
    logic             zero_s;
    logic             s1_adv_s;
    logic             s2_adv_s;

    // Sum bit i is its propagate XOR the carry out of bit i-1 (carry-in is zero).
    assign sum_s = in_P0 ^ {in_GG[WIDTH-2:0], 1'b0};

    // Each stage advances when it has data upstream and room (empty or draining).
    assign s2_adv_s = s1_valid_r && (!s2_valid_r || out_ready);
    assign s1_adv_s = in_valid && (!s1_valid_r || s2_adv_s);
    assign in_ready = !reset && (!s1_valid_r || s2_adv_s);

    lzc_count #(
        .W  (WIDTH + 1),
        .CW (LZW)
    ) u_lzc (
        .din   ({s1_cout_r, s1_sum_r}),
        .count (lzc_s),
        .zero  (zero_s)
    );

    // Stage 1: capture sum bits, carry-out and sign of an accepted operand.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_sum_r   <= {WIDTH{1'b0}};
            s1_cout_r  <= 1'b0;
            s1_sign_r  <= 1'b0;
        end else if (s1_adv_s) begin
            s1_valid_r <= 1'b1;
            s1_sum_r   <= sum_s;
            s1_cout_r  <= in_GG[WIDTH-1];
            s1_sign_r  <= in_sign;
        end else if (s2_adv_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2: attach leading-zero count and zero flag, hold while stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            s2_valid_r <= 1'b0;
            s2_r       <= '0;
        end else if (s2_adv_s) begin
            s2_valid_r <= 1'b1;
            s2_r.sum   <= s1_sum_r;
            s2_r.cout  <= s1_cout_r;
            s2_r.lzc   <= lzc_s;
            s2_r.zero  <= zero_s;
            s2_r.sign  <= s1_sign_r;
        end else if (out_ready) begin
            s2_valid_r <= 1'b0;
        end else begin
            s2_valid_r <= s2_valid_r;
        end
    end

    assign out_valid = s2_valid_r;
    assign out_sum   = s2_r.sum;
    assign out_cout  = s2_r.cout;
    assign out_lzc   = s2_r.lzc;
    assign out_zero  = s2_r.zero;
    assign out_sign  = s2_r.sign;

endmodule
